// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file write sequencer/arbiter.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef enum logic { INIT = 1'b0, RUN = 1'b1 } state_t;
  typedef enum logic { ALU = 1'b0, MEM = 1'b1 } req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter (bit 0 = ALU, bit 1 = MEM); combinational grant.
// No backpressure of its own: en low forces no grant and freezes the pointer.
module rr_arb2
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  import regfile_pkg::*;

  req_id_t rr_last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (rr_last == MEM) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rr_last <= MEM;
    else if (gnt[0]) rr_last <= ALU;
    else if (gnt[1]) rr_last <= MEM;
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Clears the register file after reset, then arbitrates dbg > rr(alu, mem) onto its write port.
// Latency: accepted request appears on write port next cycle; losers see ready=0 and must hold.
module regfile_wr_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREG   = regfile_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [ADDR_W-1:0] dbg_reg,
  input  logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              RegWrite,
  output logic              init_done,
  output logic [15:0]       conflict_cnt
);
  import regfile_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              run, last_idx, xfer, contended;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  assign run      = (state == RUN);
  assign last_idx = (idx == ADDR_W'(NREG - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && last_idx) state_nxt = RUN;
  end

  rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .req ({mem_valid, alu_valid}),
    .en  (run && !dbg_valid),
    .gnt (gnt)
  );

  assign dbg_ready = run && dbg_valid;
  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];
  assign xfer      = dbg_ready || alu_ready || mem_ready;
  assign contended = run && ((dbg_valid && alu_valid) || (dbg_valid && mem_valid) ||
                             (alu_valid && mem_valid));

  always_comb begin
    sel_reg  = alu_reg;
    sel_data = alu_data;
    if (dbg_ready) begin
      sel_reg  = dbg_reg;
      sel_data = dbg_data;
    end else if (mem_ready) begin
      sel_reg  = mem_reg;
      sel_data = mem_data;
    end
  end

  // Register 0 is hardwired zero in the file: accept the transfer but never strobe it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      write_reg  <= '0;
      write_data <= '0;
      RegWrite   <= 1'b0;
      init_done  <= 1'b0;
    end else if (!run) begin
      RegWrite   <= 1'b1;
      write_reg  <= idx;
      write_data <= '0;
      idx        <= idx + ADDR_W'(1);
      if (last_idx) init_done <= 1'b1;
    end else if (xfer && sel_reg != '0) begin
      RegWrite   <= 1'b1;
      write_reg  <= sel_reg;
      write_data <= sel_data;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       conflict_cnt <= '0;
    else if (contended && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Sequencer and write-port arbiter for the 32×32 MIPS register file (`Registers`). After reset it clears every register to zero in a fixed sweep, then shares the file's single write port (`write_reg`/`write_data`/`RegWrite`) between three writeback sources: ALU, memory load and debug. It sits between the pipeline writeback stage and `Registers`. It drives that module's write inputs directly and leaves its read ports untouched.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width
- `NREG`, 32, number of registers swept in INIT; must equal 2^ADDR_W

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset asserted)
- `alu_valid`  in  1  ALU writeback request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_reg`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `mem_valid`  in  1  memory-load writeback request
- `mem_ready`  out  1  memory-load request accepted this cycle
- `mem_reg`  in  ADDR_W  memory-load destination register
- `mem_data`  in  DATA_W  memory-load data
- `dbg_valid`  in  1  debug write request
- `dbg_ready`  out  1  debug request accepted this cycle
- `dbg_reg`  in  ADDR_W  debug destination register
- `dbg_data`  in  DATA_W  debug write data
- `write_reg`  out  ADDR_W  to `Registers.write_reg`; registered
- `write_data`  out  DATA_W  to `Registers.write_data`; registered
- `RegWrite`  out  1  to `Registers.RegWrite`; registered
- `init_done`  out  1  high once the clear sweep is complete
- `conflict_cnt`  out  16  saturating count of contended cycles

## Operation
- FSM has two states: INIT and RUN. Reset forces INIT.
- **INIT:** a sweep index `idx` counts 0..NREG-1, one step per cycle.
  - Each edge loads `RegWrite`=1, `write_reg`=idx, `write_data`=0, then increments `idx`.
  - The edge that loads idx=NREG-1 also moves the FSM to RUN.
  - All `*_ready` are 0 throughout INIT.
- **RUN:** readies are combinational from the valids and the arbiter state. A transfer occurs when valid & ready are both high.
  - Priority: `dbg` is fixed-highest.
  - `alu` and `mem` arbitrate round-robin. Pointer `rr_last` records the last of the two granted. When both are valid and `dbg` is not, grant the one ≠ `rr_last`.
  - `rr_last` updates only on an alu or mem grant. A dbg grant leaves it unchanged.
  - At most one ready is high per cycle. Ready never rises without its valid.
  - Writes to register 0 are accepted (ready=1), but `RegWrite` is held 0 for that transfer.
- **Requester contract:** a requester holds valid, reg and data stable until accepted. The arbiter neither buffers nor queues.
- **conflict_cnt:** increments in every RUN cycle where at least 2 valids are high. It saturates at 0xFFFF and is cleared only by reset.

## Timing
- **Reset values:** `write_reg`=0, `write_data`=0, `RegWrite`=0, `init_done`=0, `conflict_cnt`=0, all readies 0, `idx`=0, `rr_last`=MEM (so ALU wins the first tie).
- **INIT duration:** `RegWrite` is high for exactly NREG consecutive cycles, starting at the first rising edge after `rst` releases.
- **init_done:** rises at the edge that loads the last sweep write and stays high until reset.
- **Write latency:** a transfer accepted in cycle N produces `RegWrite`=1 with that reg and data for exactly cycle N+1. Back-to-back transfers therefore give continuous `RegWrite`.
- **Idle:** a RUN cycle with no transfer (or a reg-0 transfer) loads `RegWrite`=0. `write_reg` and `write_data` hold their previous values.
- **Reset mid-operation:** asserting `rst` clears everything immediately. A pending output write is dropped, and the sweep restarts from idx=0 after release.

## Structure
- Package `regfile_pkg` holds:
  - the `ADDR_W`, `DATA_W` and `NREG` constants
  - the state typedef {INIT, RUN}
  - the requester-id typedef {ALU, MEM}
- Sub-module `rr_arb2` is a 2-way round-robin arbiter holding `rr_last`, with inputs `req[1:0]` and `en` and output `gnt[1:0]`.
- The top level owns the FSM, the sweep counter, the dbg override, the output registers and `conflict_cnt`.

## Test plan
- **Reset and sweep:** release `rst` → `RegWrite`=1 for exactly 32 cycles with `write_reg`=0..31 and `write_data`=0. `init_done` rises on the 32nd edge. Readies are 0 throughout.
- **Single ALU write:** alu_valid, reg 10, data 9 → `alu_ready`=1 the same cycle, then {`RegWrite`=1, 10, 9} on the next cycle. A follow-up read of reg 10 through `Registers` returns 9.
- **ALU/MEM contention:** alu (4, 18) and mem (8, 36) valid and held for 2 cycles → ALU is granted first, then MEM. Outputs show (4, 18) then (8, 36). `conflict_cnt`=1.
- **Debug override:** dbg (3, 0xDEAD) plus alu and mem, all valid → dbg is granted first, `rr_last` is unchanged, and the round-robin between alu and mem then resumes as before.
- **Register 0 write:** mem valid with reg 0 → `mem_ready`=1, and `RegWrite` stays 0 on the next cycle.
- **Reset mid-run:** assert `rst` the same cycle a write is accepted → no `RegWrite` pulse for that write, `init_done`=0, and the sweep restarts at reg 0 after release.
